// File: rtl/debug_display_unit.sv
`default_nettype none
// ============================================================================
//  Module   : debug_display_unit
//  Purpose  : Shows one selected 32-bit debug register in hex on a
//             multiplexed, active-low seven-segment display, and drives a
//             heartbeat LED and a pulse-stretched instruction-commit LED.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, all state on the rising edge
//    reset_n     in   asynchronous active-low reset
//    sel         in   debug register index
//    page        in   4-digit build: 0 = bits 15:0, 1 = bits 31:16
//    regs        in   flattened registers, register i at [32*i+31:32*i]
//    commit      in   one-cycle commit strobe
//    seg         out  segments {g,f,e,d,c,b,a}, active-low
//    dp          out  decimal point, active-low
//    an          out  digit enables, active-low
//    led_hb      out  heartbeat, period 2*HB_DIV cycles
//    led_commit  out  high for STRETCH cycles after the latest commit
// ============================================================================
module debug_display_unit #(
    parameter int NUM_REGS = 32,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100_000,
    parameter int HB_DIV   = 50_000_000,
    parameter int STRETCH  = 10_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [$clog2(NUM_REGS)-1:0]   sel,
    input  logic                          page,
    input  logic [NUM_REGS*32-1:0]        regs,
    input  logic                          commit,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [DIGITS-1:0]             an,
    output logic                          led_hb,
    output logic                          led_commit
);

    localparam int SEL_W   = $clog2(NUM_REGS);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int DIG_W   = $clog2(DIGITS);
    localparam int HB_W    = $clog2(HB_DIV);
    localparam int CMT_W   = $clog2(STRETCH + 1);

    // ------------------------------------------------------------------
    // State registers and next-state values
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [DIG_W-1:0]   digit_q,   digit_d;
    logic [31:0]        snap_q,    snap_d;
    logic               page_q,    page_d;
    logic [HB_W-1:0]    hb_cnt_q,  hb_cnt_d;
    logic               led_hb_q,  led_hb_d;
    logic [CMT_W-1:0]   cmt_cnt_q, cmt_cnt_d;
    logic               led_cmt_q, led_cmt_d;
    logic [DIGITS-1:0]  an_q,      an_d;
    logic [6:0]         seg_q,     seg_d;
    logic               dp_q,      dp_d;

    logic               tick_w;
    logic               frame_w;
    logic               hb_wrap_w;
    logic [31:0]        sel_word_w;
    logic [31:0]        shown_w;
    logic [3:0]         nibble_w;

    // Hex digit to active-low {g,f,e,d,c,b,a} glyph; b and d are lowercase.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Register selection: an index with no matching register reads zero.
    // ------------------------------------------------------------------
    always_comb begin
        sel_word_w = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word_w = regs[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan timing, snapshot, heartbeat and commit stretch
    // ------------------------------------------------------------------
    always_comb begin
        tick_w  = (presc_q == PRESC_W'(SCAN_DIV - 1));
        presc_d = tick_w ? '0 : presc_q + 1'b1;

        digit_d = digit_q;
        if (tick_w) begin
            digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end

        // The snapshot only moves when the last digit finishes its dwell,
        // so a whole scan always shows one consistent word.
        frame_w = tick_w && (digit_q == DIG_W'(DIGITS - 1));
        snap_d  = frame_w ? sel_word_w : snap_q;
        page_d  = frame_w ? page       : page_q;

        hb_wrap_w = (hb_cnt_q == HB_W'(HB_DIV - 1));
        hb_cnt_d  = hb_wrap_w ? '0 : hb_cnt_q + 1'b1;
        led_hb_d  = led_hb_q ^ hb_wrap_w;

        // Saturating down-counter; a new strobe reloads it, so back-to-back
        // strobes keep it non-zero and it can never wrap.
        if (commit) begin
            cmt_cnt_d = CMT_W'(STRETCH);
        end else if (cmt_cnt_q != '0) begin
            cmt_cnt_d = cmt_cnt_q - 1'b1;
        end else begin
            cmt_cnt_d = cmt_cnt_q;
        end
        // Registering the next count puts the LED high in the very cycle
        // after the strobe.
        led_cmt_d = (cmt_cnt_d != '0);
    end

    // ------------------------------------------------------------------
    // Display content for the digit currently being scanned
    // ------------------------------------------------------------------
    always_comb begin
        shown_w = snap_q;
        if (DIGITS == 4 && page_q) begin
            shown_w = {16'h0, snap_q[31:16]};
        end

        nibble_w = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_q == DIG_W'(k)) begin
                nibble_w = shown_w[4*k +: 4];
            end
        end

        an_d  = ~(DIGITS'(1) << digit_q);
        seg_d = hex_glyph(nibble_w);
        // Decimal point on the leftmost digit flags the upper half-word.
        dp_d  = !((DIGITS == 4) && page_q && (digit_q == DIG_W'(DIGITS - 1)));
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            digit_q   <= '0;
            snap_q    <= 32'h0;
            page_q    <= 1'b0;
            hb_cnt_q  <= '0;
            led_hb_q  <= 1'b0;
            cmt_cnt_q <= '0;
            led_cmt_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            snap_q    <= snap_d;
            page_q    <= page_d;
            hb_cnt_q  <= hb_cnt_d;
            led_hb_q  <= led_hb_d;
            cmt_cnt_q <= cmt_cnt_d;
            led_cmt_q <= led_cmt_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign led_hb     = led_hb_q;
    assign led_commit = led_cmt_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_display_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_display_unit
//  Purpose  : Self-checking bench for debug_display_unit. A 4-digit /
//             32-register build and an 8-digit / 24-register build run side
//             by side against a cycle-count based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_display_unit;

    localparam int S  = 4;   // scan dwell
    localparam int H  = 8;   // heartbeat divider
    localparam int ST = 5;   // commit stretch

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [4:0]    sel4, sel8;
    logic          page4, page8;
    logic [1023:0] regs4;
    logic [767:0]  regs8;
    logic          commit4, commit8;
    logic [6:0]    seg4, seg8;
    logic          dp4, dp8;
    logic [3:0]    an4;
    logic [7:0]    an8;
    logic          hb4, hb8, lc4, lc8;

    debug_display_unit #(
        .NUM_REGS(32), .DIGITS(4), .SCAN_DIV(S), .HB_DIV(H), .STRETCH(ST)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .sel(sel4), .page(page4), .regs(regs4),
        .commit(commit4), .seg(seg4), .dp(dp4), .an(an4), .led_hb(hb4),
        .led_commit(lc4)
    );

    debug_display_unit #(
        .NUM_REGS(24), .DIGITS(8), .SCAN_DIV(S), .HB_DIV(H), .STRETCH(ST)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .sel(sel8), .page(page8), .regs(regs8),
        .commit(commit8), .seg(seg8), .dp(dp8), .an(an8), .led_hb(hb8),
        .led_commit(lc8)
    );

    // Standard active-low hex glyphs {g,f,e,d,c,b,a}
    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    // Reference model: everything derives from n, the number of rising
    // edges since reset was released.
    int          n;
    logic [31:0] snap4, snap8;
    logic        pg4;
    int          last4, last8;   // edge number of the latest sampled commit

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n     = 0;
        snap4 = 32'h0;
        snap8 = 32'h0;
        pg4   = 1'b0;
        last4 = -100;
        last8 = -100;
    endtask

    task automatic check_reset_outputs();
        chk("rst_an4",  32'(an4),  32'hF);
        chk("rst_seg4", 32'(seg4), 32'h7F);
        chk("rst_dp4",  32'(dp4),  32'h1);
        chk("rst_hb4",  32'(hb4),  32'h0);
        chk("rst_lc4",  32'(lc4),  32'h0);
        chk("rst_an8",  32'(an8),  32'hFF);
        chk("rst_seg8", 32'(seg8), 32'h7F);
        chk("rst_dp8",  32'(dp8),  32'h1);
        chk("rst_hb8",  32'(hb8),  32'h0);
        chk("rst_lc8",  32'(lc8),  32'h0);
    endtask

    // One clock edge: predict outputs from the pre-edge model state, apply
    // the edge to the model, then compare just after the edge.
    task automatic edge_check();
        int          d4, d8;
        logic [31:0] w4;
        logic [3:0]  ea4;
        logic [7:0]  ea8;
        logic [6:0]  es4, es8;
        logic        ed4, ehb, elc4, elc8;

        d4  = (n / S) % 4;
        d8  = (n / S) % 8;
        ea4 = ~(4'b0001 << d4);
        ea8 = ~(8'h01 << d8);
        w4  = pg4 ? (snap4 >> 16) : snap4;
        es4 = GLYPH[int'((w4 >> (4 * d4)) & 32'hF)];
        es8 = GLYPH[int'((snap8 >> (4 * d8)) & 32'hF)];
        ed4 = !(pg4 && d4 == 3);

        if ((n + 1) % (S * 4) == 0) begin
            snap4 = regs4[32*sel4 +: 32];
            pg4   = page4;
        end
        if ((n + 1) % (S * 8) == 0) begin
            if (sel8 < 5'd24) snap8 = regs8[32*sel8 +: 32];
            else              snap8 = 32'h0;
        end
        if (commit4) last4 = n + 1;
        if (commit8) last8 = n + 1;

        @(posedge clk);
        #1;
        n++;
        ehb  = ((n / H) % 2) == 1;
        elc4 = (n - last4) < ST;
        elc8 = (n - last8) < ST;

        chk("an4",  32'(an4),  32'(ea4));
        chk("seg4", 32'(seg4), 32'(es4));
        chk("dp4",  32'(dp4),  32'(ed4));
        chk("an8",  32'(an8),  32'(ea8));
        chk("seg8", 32'(seg8), 32'(es8));
        chk("dp8",  32'(dp8),  32'h1);
        chk("hb4",  32'(hb4),  32'(ehb));
        chk("hb8",  32'(hb8),  32'(ehb));
        chk("lc4",  32'(lc4),  32'(elc4));
        chk("lc8",  32'(lc8),  32'(elc8));
    endtask

    task automatic randomize_inputs();
        regs4[32*$urandom_range(0, 31) +: 32] = $urandom();
        regs8[32*$urandom_range(0, 23) +: 32] = $urandom();
        sel4    = 5'($urandom_range(0, 31));
        sel8    = 5'($urandom_range(0, 31));
        page4   = 1'($urandom_range(0, 1));
        page8   = 1'($urandom_range(0, 1));
        commit4 = ($urandom_range(0, 7) == 0);
        commit8 = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        reset_n = 1'b0;
        sel4 = 5'd0; sel8 = 5'd0; page4 = 1'b0; page8 = 1'b0;
        commit4 = 1'b0; commit8 = 1'b0;
        regs4 = '0; regs8 = '0;
        model_reset();

        #12;
        check_reset_outputs();

        // Directed: 4-digit shows DEADBEEF lower then upper half,
        // 8-digit switches register mid-frame.
        regs4[32*3 +: 32] = 32'hDEAD_BEEF;
        sel4 = 5'd3;
        regs8[32*0 +: 32] = 32'hCAFE_F00D;
        regs8[32*5 +: 32] = 32'h0123_4567;
        sel8 = 5'd0;

        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        repeat (16) edge_check();            // frame 1: zeros
        page4 = 1'b1;                        // takes effect at next boundary
        repeat (17) edge_check();            // n = 33
        chk("dir_an4_d0_upper",  32'(an4),  32'hE);
        chk("dir_seg4_D_upper",  32'(seg4), 32'h21);
        repeat (7) edge_check();             // n = 40, mid-frame
        sel8 = 5'd5;
        repeat (10) edge_check();            // n = 50

        // Commit pulses: single, retrigger, then a consecutive burst
        commit4 = 1'b1; edge_check();
        commit4 = 1'b0; edge_check(); edge_check();
        commit4 = 1'b1; edge_check();
        commit4 = 1'b0;
        commit8 = 1'b1; repeat (6) edge_check();
        commit8 = 1'b0;                      // n = 60
        repeat (5) edge_check();             // n = 65: new word, digit 0
        chk("dir_seg8_new_word", 32'(seg8), 32'h78);
        repeat (31) edge_check();

        // Randomized free run
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            edge_check();
        end
        commit4 = 1'b0; commit8 = 1'b0;

        // Asynchronous reset in the middle of a dwell
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();

        // Out-of-range select on the 24-register build
        sel8 = 5'd24;
        for (int r = 0; r < 24; r++) regs8[32*r +: 32] = $urandom() | 32'h1;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (70) edge_check();
        chk("dir_seg8_oor_zero", 32'(seg8), 32'h40);

        for (int i = 0; i < 150; i++) begin
            randomize_inputs();
            edge_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
